delay_sched: RTL and testbench

Round-robin scheduler that shares a single bounded delay counter among `NREQ` requesters. A requester raises `req` with a delay length, the scheduler grants it the counter, and the counter runs to completion. The scheduler then pulses that requester's `done` bit and releases the counter. It sits between the timing clients and the shared delay-counter resource, replacing per-client delay counters.

---
 rtl/delay_sched_pkg.sv | 40 ++++
 rtl/delay_sched_rr_arbiter.sv | 28 ++
 rtl/delay_sched.sv | 130 +++++++++++++
 tb/tb_delay_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_sched_pkg.sv
//------------------------------------------------------------------------------
// Module   : delay_sched_pkg
// Brief    : Shared types, defaults and round-robin pick helper for delay_sched.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package delay_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_CBITS  = 14;
  localparam int DEF_MAXLEN = 15000;
  localparam int RR_MAXN    = 8;

  // First set request at or after ptr, searching upward modulo nreq.
  function automatic int rr_pick(input logic [RR_MAXN-1:0] req, input int ptr, input int nreq);
    int win;
    int idx;
    logic found;
    win   = 0;
    found = 1'b0;
    for (int k = 0; k < RR_MAXN; k++) begin
      idx = (ptr + k) % nreq;
      if (k < nreq && !found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/delay_sched_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick of one requester starting at ptr.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import delay_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   pick,
  output logic            valid
);

  logic [RR_MAXN-1:0] w_req_ext;

  assign w_req_ext = RR_MAXN'(req);
  assign pick      = PW'(rr_pick(w_req_ext, int'(ptr), NREQ));
  assign valid     = |req;

endmodule

`default_nettype wire

// File: rtl/delay_sched.sv
//------------------------------------------------------------------------------
// Module   : delay_sched
// Brief    : Round-robin owner of one shared, bounded delay counter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module delay_sched
  import delay_sched_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int CBITS  = DEF_CBITS,
  parameter int MAXLEN = DEF_MAXLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CBITS-1:0] len_flat,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [CBITS-1:0]      cnt,
  output logic                  err
);

  localparam int              PW       = $clog2(NREQ);
  localparam logic [CBITS-1:0] c_maxlen = CBITS'(MAXLEN);

  state_t           r_state, w_state_nx;
  logic [NREQ-1:0]  r_gnt, w_gnt_nx;
  logic [NREQ-1:0]  r_done, w_done_nx;
  logic [CBITS-1:0] r_cnt, w_cnt_nx;
  logic             r_err, w_err_nx;
  logic [PW-1:0]    r_ptr, w_ptr_nx;
  logic [PW-1:0]    r_own, w_own_nx;

  logic [PW-1:0]    w_pick;
  logic             w_valid;
  logic [CBITS-1:0] w_len;
  logic [PW-1:0]    w_own_inc;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req   (req),
    .ptr   (r_ptr),
    .pick  (w_pick),
    .valid (w_valid)
  );

  assign w_len     = len_flat[int'(w_pick)*CBITS +: CBITS];
  assign w_own_inc = (r_own == PW'(NREQ-1)) ? '0 : r_own + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_ptr   <= '0;
      r_own   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_done  <= w_done_nx;
      r_cnt   <= w_cnt_nx;
      r_err   <= w_err_nx;
      r_ptr   <= w_ptr_nx;
      r_own   <= w_own_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_done_nx  = '0;
    w_cnt_nx   = r_cnt;
    w_err_nx   = 1'b0;
    w_ptr_nx   = r_ptr;
    w_own_nx   = r_own;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_gnt_nx   = NREQ'(1) << w_pick;
          w_cnt_nx   = (w_len > c_maxlen) ? c_maxlen : w_len;
          w_err_nx   = (w_len > c_maxlen);
          w_own_nx   = w_pick;
          w_state_nx = COUNT;
        end
      end
      COUNT: begin
        // Abort takes priority over completion, even on the final count.
        if (!req[r_own]) begin
          w_gnt_nx   = '0;
          w_cnt_nx   = '0;
          w_ptr_nx   = w_own_inc;
          w_state_nx = IDLE;
        end else if (r_cnt == '0) begin
          w_done_nx  = r_gnt;
          w_state_nx = DONE;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      DONE: begin
        w_gnt_nx   = '0;
        w_ptr_nx   = w_own_inc;
        w_state_nx = IDLE;
      end
      default: begin
        w_gnt_nx   = '0;
        w_cnt_nx   = '0;
        w_state_nx = IDLE;
      end
    endcase
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign cnt  = r_cnt;
  assign err  = r_err;
  assign busy = (r_state == COUNT) || (r_state == DONE);

  a_gnt_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_done_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(done));
  a_done_gnt:    assert property (@(posedge clk) disable iff (rst) ((done & ~gnt) == '0));
  a_cnt_max:     assert property (@(posedge clk) disable iff (rst) (cnt <= c_maxlen));

endmodule

`default_nettype wire

// File: tb/tb_delay_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_delay_sched
// Brief    : Directed and random checks of delay_sched against a timeline model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_delay_sched;

  localparam int N  = 4;
  localparam int CB = 14;
  localparam int MX = 15000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*CB-1:0] len_flat = '0;
  logic [N-1:0]    gnt, done;
  logic            busy, err;
  logic [CB-1:0]   cnt;

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;

  // Model: current owner, cycles elapsed since its grant, clamped length.
  int m_own = -1;
  int m_e   = 0;
  int m_L   = 0;
  int m_ptr = 0;
  bit m_clamp = 1'b0;

  always #5 clk = ~clk;

  delay_sched #(.NREQ(N), .CBITS(CB), .MAXLEN(MX)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .len_flat (len_flat),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .cnt      (cnt),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_len(input int i, input int v);
    len_flat[i*CB +: CB] = CB'(v);
  endtask

  function automatic void model_step();
    if (rst) begin
      m_own = -1;
      m_ptr = 0;
    end else if (m_own < 0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (m_own < 0 && req[i]) m_own = i;
      end
      if (m_own >= 0) begin
        int l;
        l = int'(len_flat[m_own*CB +: CB]);
        m_clamp = (l > MX);
        m_L = m_clamp ? MX : l;
        m_e = 0;
      end
    end else if (m_e <= m_L) begin
      if (!req[m_own]) begin
        m_ptr = (m_own + 1) % N;
        m_own = -1;
      end else begin
        m_e++;
      end
    end else begin
      m_ptr = (m_own + 1) % N;
      m_own = -1;
    end
  endfunction

  task automatic cyc();
    logic [N-1:0] eg;
    @(posedge clk);
    model_step();
    #1;
    eg = (m_own >= 0) ? N'(1 << m_own) : '0;
    chk("gnt",  gnt,  eg);
    chk("done", done, (m_own >= 0 && m_e == m_L + 1) ? eg : '0);
    chk("busy", busy, m_own >= 0);
    chk("cnt",  cnt,  (m_own >= 0 && m_e <= m_L) ? m_L - m_e : 0);
    chk("err",  err,  m_own >= 0 && m_e == 0 && m_clamp);
  endtask

  // idx < 0 waits for any done bit; lat = edges taken, -1 on timeout.
  task automatic wait_done(input int idx, input int budget, output int lat, output int who);
    lat = -1;
    who = -1;
    for (int n = 1; n <= budget; n++) begin
      cyc();
      if ((idx < 0 && |done) || (idx >= 0 && done[idx])) begin
        lat = n;
        for (int i = 0; i < N; i++) if (done[i]) who = i;
        break;
      end
    end
  endtask

  initial begin
    int lat, who, prev;

    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_gnt", gnt, 0);
    chk("rst_cnt", cnt, 0);
    rst = 1'b0;
    cyc();

    // Single request, len 5: done 7 edges after req.
    set_len(0, 5);
    req = 4'b0001;
    cyc();
    chk("single_gnt", gnt, 4'b0001);
    chk("single_cnt", cnt, 5);
    wait_done(0, 20, lat, who);
    chk("single_lat", lat + 1, 7);
    req = '0;
    cyc();

    // Zero length on requester 1.
    set_len(1, 0);
    req = 4'b0010;
    wait_done(1, 10, lat, who);
    chk("zero_lat", lat, 2);
    req = '0;
    cyc();

    // Contention: ptr now at 2, so service order 2,3,0,1,...
    for (int i = 0; i < N; i++) set_len(i, 2);
    req = 4'b1111;
    prev = -1;
    for (int k = 0; k < 8; k++) begin
      wait_done(-1, 20, lat, who);
      if (k == 0) begin
        chk("cont_first_idx", who, 2);
        chk("cont_first_lat", lat, 4);
      end else begin
        chk("cont_gap", lat, 5);
        chk("cont_order", who, (prev + 1) % N);
      end
      prev = who;
    end
    req = '0;
    cyc();

    // Abort requester 2 at cnt 3; requester 3 is next.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_len(2, 6);
    set_len(3, 1);
    req = 4'b1100;
    for (int n = 0; n < 20; n++) begin
      cyc();
      if (gnt[2] && cnt == 3) break;
    end
    req = 4'b1000;
    cyc();
    chk("abort_gnt", gnt, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    cyc();
    chk("abort_next_gnt", gnt, 4'b1000);
    chk("abort_next_cnt", cnt, 1);
    wait_done(3, 10, lat, who);
    req = '0;
    cyc();

    // Reset mid-count at cnt 7; held request re-granted with full length.
    set_len(0, 10);
    req = 4'b0001;
    for (int n = 0; n < 20; n++) begin
      cyc();
      if (gnt[0] && cnt == 7) break;
    end
    rst = 1'b1;
    cyc();
    chk("midrst_gnt", gnt, 0);
    chk("midrst_cnt", cnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    rst = 1'b0;
    cyc();
    chk("midrst_regnt", gnt, 4'b0001);
    chk("midrst_recnt", cnt, 10);
    wait_done(0, 20, lat, who);
    req = '0;
    cyc();

    // Length altered after grant must not move done.
    set_len(1, 4);
    req = 4'b0010;
    cyc();
    set_len(1, 9);
    wait_done(1, 20, lat, who);
    chk("lenchg_lat", lat + 1, 6);
    req = '0;
    cyc();

    // Oversized length is clamped and flagged.
    set_len(0, 16000);
    req = 4'b0001;
    cyc();
    chk("clamp_err", err, 1);
    chk("clamp_cnt", cnt, MX);
    wait_done(0, MX + 10, lat, who);
    chk("clamp_lat", lat + 1, MX + 2);
    req = '0;
    cyc();

    // Random traffic with aborts, len changes and occasional reset.
    for (int t = 0; t < 4000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (done[i] ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 39) == 0)) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          set_len(i, $urandom_range(0, 9));
          req[i] = 1'b1;
        end
        if ($urandom_range(0, 15) == 0) set_len(i, $urandom_range(0, 9));
      end
      rst = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
